seq_restoring_div: RTL and testbench



---
 rtl/div_pkg.sv | 25 ++
 rtl/seq_restoring_div_ripple_sub.sv | 40 ++++
 rtl/seq_restoring_div.sv | 123 ++++++++++++
 tb/tb_seq_restoring_div.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_restoring_div_ripple_sub.sv
// Ripple-borrow subtractor built from a chain of single-bit full subtractors;
// the final borrow-out reports whether a < b.
module full_sub (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);

  assign o_diff = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~i_a & i_bin) | (i_b & i_bin);

endmodule

module ripple_sub #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out
);

  logic [WIDTH:0] w_borrow;

  assign w_borrow[0]  = 1'b0;
  assign o_borrow_out = w_borrow[WIDTH];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    full_sub u_cell (
      .i_a   (i_a[gi]),
      .i_b   (i_b[gi]),
      .i_bin (w_borrow[gi]),
      .o_diff(o_diff[gi]),
      .o_bout(w_borrow[gi+1])
    );
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Iterative unsigned restoring divider producing one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic             r_out_valid;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_r_next;
  logic             w_unused;

  assign w_shifted = {r_r, r_q[WIDTH-1]};

  ripple_sub #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a         (w_shifted),
    .i_b         ({1'b0, r_d}),
    .o_diff      (w_diff),
    .o_borrow_out(w_borrow)
  );

  // A successful trial leaves diff < D, so its top bit is always zero.
  assign w_unused = w_diff[WIDTH];
  assign w_q_next = {r_q[WIDTH-2:0], ~w_borrow};
  assign w_r_next = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = r_out_valid;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_d         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_d   <= divisor;
            r_q   <= dividend;
            r_r   <= '0;
            r_cnt <= CNT_LAST;
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= ST_CALC;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_q <= w_q_next;
          r_r <= w_r_next;
          if (r_cnt == '0) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and randomised checks of seq_restoring_div (WIDTH=8): results,
// latency, backpressure, ignored requests and asynchronous abort.
module tb_seq_restoring_div;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_restoring_div #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble them to prove they were latched.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input string tag);
    check(32'(in_ready), 32'd1, {tag, " in_ready before accept"});
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check(32'(n), 32'(exp_lat), {tag, " latency"});
  endtask

  task automatic check_result(input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                              input string tag);
    check(32'(quotient), 32'(eq), {tag, " quotient"});
    check(32'(remainder), 32'(er), {tag, " remainder"});
    check(32'(div_by_zero), 32'(edbz), {tag, " div_by_zero"});
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check(32'(out_valid), 32'd0, {tag, " out_valid drop"});
    check(32'(in_ready), 32'd1, {tag, " in_ready return"});
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic edbz, input string tag);
    start_op(a, b, tag);
    wait_done(edbz ? 0 : 8, tag);
    check_result(eq, er, edbz, tag);
    release_op(tag);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dividend  = 8'd0;
    divisor   = 8'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(32'(out_valid), 32'd0, "reset out_valid");
    check(32'(quotient), 32'd0, "reset quotient");
    check(32'(remainder), 32'd0, "reset remainder");
    check(32'(div_by_zero), 32'd0, "reset div_by_zero");
    check(32'(in_ready), 32'd1, "reset in_ready");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'd100, 8'd7,   8'd14,  8'd2,  1'b0, "100/7");
    run_op(8'd55,  8'd0,   8'hFF,  8'd55, 1'b1, "55/0");
    run_op(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, "5/9");
    run_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, "255/1");
    run_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, "255/255");
    run_op(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, "0/3");

    // Backpressure, with stray requests during CALC and DONE.
    out_ready = 1'b0;
    start_op(8'd100, 8'd7, "bp");
    @(posedge clk); #1;
    check(32'(in_ready), 32'd0, "bp in_ready in CALC");
    dividend = 8'd9;
    divisor  = 8'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(6, "bp");
    check_result(8'd14, 8'd2, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      dividend = 8'd9;
      divisor  = 8'd0;
      @(posedge clk); #1;
      check(32'(out_valid), 32'd1, "bp hold out_valid");
      check(32'(in_ready), 32'd0, "bp hold in_ready");
      check_result(8'd14, 8'd2, 1'b0, "bp hold");
    end
    in_valid = 1'b0;
    release_op("bp");
    repeat (2) @(posedge clk);
    #1;
    check(32'(out_valid), 32'd0, "bp no stray op");

    // Abort three iterations into CALC.
    start_op(8'd50, 8'd3, "abort");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check(32'(out_valid), 32'd0, "abort out_valid");
    check(32'(quotient), 32'd0, "abort quotient");
    check(32'(remainder), 32'd0, "abort remainder");
    check(32'(in_ready), 32'd1, "abort in_ready");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b0, "200/13");

    for (int k = 0; k < 2000; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        eq = 8'hFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op(a, b, eq, er, (b == 8'd0), $sformatf("rnd%0d %0d/%0d", k, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
